// File: rtl/wb_pkg.sv
// Shared write-back types and constants.
// Used by the write-back arbiter and its result FIFO.
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of pending multi-cycle write-back results.
// Per-slot destinations and valid bits are exposed for hazard tracking.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             PUSH,
    input  wb_req_t                          PUSH_REQ,
    input  logic                             POP,
    output wb_req_t                          HEAD,
    output logic                             FULL,
    output logic                             EMPTY,
    output logic [$clog2(DEPTH):0]           LEVEL,
    output logic [DEPTH-1:0][REG_AW-1:0]     ENTRY_RD,
    output logic [DEPTH-1:0]                 VALID
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t [DEPTH-1:0] mem;
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;
    logic [AW:0]         count;
    logic [DEPTH-1:0]    vld;

    // Pointer, occupancy and slot-valid bookkeeping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (POP) begin
                rptr      <= rptr + AW'(1);
                vld[rptr] <= 1'b0;
            end
            if (PUSH) begin
                wptr      <= wptr + AW'(1);
                vld[wptr] <= 1'b1;
            end
            unique case ({PUSH, POP})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are qualified by the valid bits.
    always_ff @(posedge CLK) begin
        if (PUSH) mem[wptr] <= PUSH_REQ;
    end

    // Per-slot destination view for the pending mask.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ENTRY_RD[i] = mem[i].rd;
        end
    end

    assign HEAD  = mem[rptr];
    assign FULL  = (count == (AW+1)'(DEPTH));
    assign EMPTY = (count == '0);
    assign LEVEL = count;
    assign VALID = vld;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: ALU port A over buffered port B.
// Optional macro WB_FIFO_BYPASS_EN sends B straight out when idle.
module wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       A_VALID,
    input  logic [wb_pkg::REG_AW-1:0]  A_RD,
    input  logic [XLEN-1:0]            A_DATA,
    input  logic                       B_VALID,
    output logic                       B_READY,
    input  logic [wb_pkg::REG_AW-1:0]  B_RD,
    input  logic [XLEN-1:0]            B_DATA,
    output logic                       WE3,
    output logic [wb_pkg::REG_AW-1:0]  A3,
    output logic [XLEN-1:0]            WD3,
    output logic [31:0]                PEND,
    output logic [$clog2(DEPTH):0]     FIFO_LEVEL
);

    import wb_pkg::*;

    wb_req_t                     b_req;
    wb_req_t                     head;
    logic                        full;
    logic                        empty;
    logic [DEPTH-1:0][REG_AW-1:0] ent_rd;
    logic [DEPTH-1:0]            ent_vld;

    logic              a_wr;
    logic              b_xfer;
    logic              b_live;
    logic              pop;
    logic              push;
    logic              bypass;
    logic              nxt_we;
    logic [REG_AW-1:0] nxt_rd;
    logic [XLEN-1:0]   nxt_data;

    assign B_READY = !full && !RST;
    assign a_wr    = A_VALID && (A_RD != '0);
    assign b_xfer  = B_VALID && B_READY;
    assign b_live  = b_xfer && (B_RD != '0);
    assign pop     = !a_wr && !empty;

`ifdef WB_FIFO_BYPASS_EN
    assign bypass  = !a_wr && empty && b_live;
`else
    assign bypass  = 1'b0;
`endif

    assign push    = b_live && !bypass;
    assign b_req.rd   = B_RD;
    assign b_req.data = B_DATA;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .PUSH     (push),
        .PUSH_REQ (b_req),
        .POP      (pop),
        .HEAD     (head),
        .FULL     (full),
        .EMPTY    (empty),
        .LEVEL    (FIFO_LEVEL),
        .ENTRY_RD (ent_rd),
        .VALID    (ent_vld)
    );

    // Priority select: port A, then FIFO head, then bypassed port B.
    always_comb begin
        nxt_we   = 1'b0;
        nxt_rd   = A3;
        nxt_data = WD3;
        unique case (1'b1)
            a_wr: begin
                nxt_we   = 1'b1;
                nxt_rd   = A_RD;
                nxt_data = A_DATA;
            end
            pop: begin
                nxt_we   = 1'b1;
                nxt_rd   = head.rd;
                nxt_data = head.data;
            end
            bypass: begin
                nxt_we   = 1'b1;
                nxt_rd   = B_RD;
                nxt_data = B_DATA;
            end
            default: ;
        endcase
    end

    // Output stage feeding the register-file write port.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            WE3 <= 1'b0;
            A3  <= '0;
            WD3 <= '0;
        end else begin
            WE3 <= nxt_we;
            A3  <= nxt_rd;
            WD3 <= nxt_data;
        end
    end

    // Pending mask: OR of destinations held in live FIFO slots.
    always_comb begin
        PEND = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i]) PEND[ent_rd[i]] = 1'b1;
        end
        PEND[0] = 1'b0;
    end

endmodule
